// File: rtl/memory_access_stage.sv
`default_nettype none
// ============================================================================
// memory_access_stage
//   Data-memory handshake, store lane steering, load alignment and MEM/WB reg.
//   Revision: 1.0
// ============================================================================
module memory_access_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           alu_result_mem_i,
  input  logic [31:0]           latest_rs2_value_mem_i,
  input  logic                  load_store_forward_sel_mem_i,
  input  logic                  reg_write_en_mem_i,
  input  logic                  is_load_instr_mem_i,
  input  logic                  is_store_instr_mem_i,
  input  logic [4:0]            rd_label_mem_i,
  input  logic [1:0]            wb_sel_mem_i,
  input  logic [31:0]           pc_mem_i,
  input  logic [2:0]            funct3_mem_i,
  output logic [31:0]           rd_value_mem_o,
  output logic                  reg_write_en_mem_o,
  output logic [4:0]            rd_label_mem_o,
  output logic                  stall_mem_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [31:0]           dmem_wdata_o,
  output logic [3:0]            dmem_be_o,
  input  logic                  dmem_ack_i,
  input  logic [31:0]           dmem_rdata_i,
  output logic [31:0]           rd_value_wb_o,
  output logic                  reg_write_en_wb_o,
  output logic [4:0]            rd_label_wb_o,
  output logic                  misaligned_exc_o
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t      state;

  logic        mem_op;
  logic        misaligned;
  logic        launch;
  logic [1:0]  byte_off;
  logic [31:0] word_addr;
  logic [31:0] store_src;
  logic [31:0] store_data;
  logic [3:0]  store_be;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] wb_value;

  assign mem_op    = is_load_instr_mem_i | is_store_instr_mem_i;
  assign byte_off  = alu_result_mem_i[1:0];
  assign word_addr = {alu_result_mem_i[31:2], 2'b00};

  // Reserved size encodings are rejected the same way as a bad alignment.
  always_comb begin
    misaligned = 1'b0;
    if (mem_op) begin
      case (funct3_mem_i)
        3'b001, 3'b101:         misaligned = alu_result_mem_i[0];
        3'b010:                 misaligned = |alu_result_mem_i[1:0];
        3'b011, 3'b110, 3'b111: misaligned = 1'b1;
        default:                misaligned = 1'b0;
      endcase
    end
  end

  assign launch      = (state == IDLE) && mem_op && !misaligned;
  assign stall_mem_o = !rst_i && (launch || ((state == ACCESS) && !dmem_ack_i));

  assign rd_value_mem_o     = (wb_sel_mem_i == 2'b10) ? (pc_mem_i + 32'd4) : alu_result_mem_i;
  assign reg_write_en_mem_o = reg_write_en_mem_i & ~misaligned;
  assign rd_label_mem_o     = rd_label_mem_i;

  assign store_src = load_store_forward_sel_mem_i ? rd_value_wb_o : latest_rs2_value_mem_i;

  always_comb begin
    store_data = store_src;
    store_be   = 4'b1111;
    if (is_store_instr_mem_i) begin
      case (funct3_mem_i[1:0])
        2'b00: begin
          store_data = {4{store_src[7:0]}};
          store_be   = 4'b0001 << byte_off;
        end
        2'b01: begin
          store_data = {2{store_src[15:0]}};
          store_be   = 4'b0011 << byte_off;
        end
        default: begin
          store_data = store_src;
          store_be   = 4'b1111;
        end
      endcase
    end
  end

  assign shifted = dmem_rdata_i >> {byte_off, 3'b000};

  always_comb begin
    case (funct3_mem_i)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign wb_value = (wb_sel_mem_i == 2'b01) ? load_data : rd_value_mem_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= IDLE;
      dmem_req_o        <= 1'b0;
      dmem_we_o         <= 1'b0;
      dmem_addr_o       <= '0;
      dmem_wdata_o      <= 32'd0;
      dmem_be_o         <= 4'd0;
      rd_value_wb_o     <= 32'd0;
      reg_write_en_wb_o <= 1'b0;
      rd_label_wb_o     <= 5'd0;
      misaligned_exc_o  <= 1'b0;
    end else begin
      misaligned_exc_o <= misaligned && (state == IDLE);

      if (!stall_mem_o) begin
        rd_value_wb_o     <= wb_value;
        reg_write_en_wb_o <= reg_write_en_mem_o;
        rd_label_wb_o     <= rd_label_mem_i;
      end

      // Bus fields are frozen for the whole access; ack only matters in ACCESS.
      case (state)
        IDLE: begin
          if (launch) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= is_store_instr_mem_i;
            dmem_addr_o  <= word_addr[ADDR_WIDTH-1:0];
            dmem_wdata_o <= store_data;
            dmem_be_o    <= store_be;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            dmem_we_o  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`default_nettype none
// Scoreboard bench for memory_access_stage: directed ops, WB results checked by a monitor.
module tb_memory_access_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] alu_result_mem_i;
  logic [31:0] latest_rs2_value_mem_i;
  logic        load_store_forward_sel_mem_i;
  logic        reg_write_en_mem_i;
  logic        is_load_instr_mem_i;
  logic        is_store_instr_mem_i;
  logic [4:0]  rd_label_mem_i;
  logic [1:0]  wb_sel_mem_i;
  logic [31:0] pc_mem_i;
  logic [2:0]  funct3_mem_i;
  logic [31:0] rd_value_mem_o;
  logic        reg_write_en_mem_o;
  logic [4:0]  rd_label_mem_o;
  logic        stall_mem_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] rd_value_wb_o;
  logic        reg_write_en_wb_o;
  logic [4:0]  rd_label_wb_o;
  logic        misaligned_exc_o;

  memory_access_stage #(.ADDR_WIDTH(32)) dut (
    .clk_i                        (clk_i),
    .rst_i                        (rst_i),
    .alu_result_mem_i             (alu_result_mem_i),
    .latest_rs2_value_mem_i       (latest_rs2_value_mem_i),
    .load_store_forward_sel_mem_i (load_store_forward_sel_mem_i),
    .reg_write_en_mem_i           (reg_write_en_mem_i),
    .is_load_instr_mem_i          (is_load_instr_mem_i),
    .is_store_instr_mem_i         (is_store_instr_mem_i),
    .rd_label_mem_i               (rd_label_mem_i),
    .wb_sel_mem_i                 (wb_sel_mem_i),
    .pc_mem_i                     (pc_mem_i),
    .funct3_mem_i                 (funct3_mem_i),
    .rd_value_mem_o               (rd_value_mem_o),
    .reg_write_en_mem_o           (reg_write_en_mem_o),
    .rd_label_mem_o               (rd_label_mem_o),
    .stall_mem_o                  (stall_mem_o),
    .dmem_req_o                   (dmem_req_o),
    .dmem_we_o                    (dmem_we_o),
    .dmem_addr_o                  (dmem_addr_o),
    .dmem_wdata_o                 (dmem_wdata_o),
    .dmem_be_o                    (dmem_be_o),
    .dmem_ack_i                   (dmem_ack_i),
    .dmem_rdata_i                 (dmem_rdata_i),
    .rd_value_wb_o                (rd_value_wb_o),
    .reg_write_en_wb_o            (reg_write_en_wb_o),
    .rd_label_wb_o                (rd_label_wb_o),
    .misaligned_exc_o             (misaligned_exc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] val;
    logic        chk_val;
    logic        we;
    logic [4:0]  rd;
    logic        exc;
    string       name;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  wb_exp_t e;
  logic    cap;
  int      checks   = 0;
  int      failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic wb_exp_t mk(input logic [31:0] v, input logic cv, input logic w,
                                 input logic [4:0] r, input logic x, input string nm);
    wb_exp_t t;
    t.val = v; t.chk_val = cv; t.we = w; t.rd = r; t.exc = x; t.name = nm;
    return t;
  endfunction

  // Monitor: every edge where the stage is not stalled retires one op into WB.
  always @(posedge clk_i) begin
    cap = !rst_i && !stall_mem_o;
    if (cap) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected: capture with empty scoreboard, got %h", rd_value_wb_o);
      end else begin
        e = exp_q.pop_front();
        if (e.chk_val) check32({"wb_value ", e.name}, rd_value_wb_o, e.val);
        check32({"wb_we ", e.name}, {31'd0, reg_write_en_wb_o}, {31'd0, e.we});
        check32({"wb_rd ", e.name}, {27'd0, rd_label_wb_o}, {27'd0, e.rd});
        check32({"exc ", e.name}, {31'd0, misaligned_exc_o}, {31'd0, e.exc});
      end
    end
  end

  task automatic drive(input logic [31:0] alu, input logic [31:0] rs2, input logic fwd,
                       input logic rwe, input logic ld, input logic st, input logic [4:0] rd,
                       input logic [1:0] wbsel, input logic [31:0] pc, input logic [2:0] f3);
    alu_result_mem_i             = alu;
    latest_rs2_value_mem_i       = rs2;
    load_store_forward_sel_mem_i = fwd;
    reg_write_en_mem_i           = rwe;
    is_load_instr_mem_i          = ld;
    is_store_instr_mem_i         = st;
    rd_label_mem_i               = rd;
    wb_sel_mem_i                 = wbsel;
    pc_mem_i                     = pc;
    funct3_mem_i                 = f3;
  endtask

  // Called at a negedge; presents one op, answers with ack at cycle ack_at, returns at a negedge.
  task automatic issue(input logic [31:0] alu, input logic [31:0] rs2, input logic fwd,
                       input logic rwe, input logic ld, input logic st, input logic [4:0] rd,
                       input logic [1:0] wbsel, input logic [31:0] pc, input logic [2:0] f3,
                       input int ack_at, input logic [31:0] rdata, input wb_exp_t ex,
                       input int exp_stall, input logic chk_bus, input logic exp_we,
                       input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input string name);
    int n;
    drive(alu, rs2, fwd, rwe, ld, st, rd, wbsel, pc, f3);
    exp_q.push_back(ex);
    n = 0;
    forever begin
      if (ack_at > 0 && n == ack_at) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rdata;
      end
      #1;
      if (n == 0) begin
        check32({"req_idle ", name}, {31'd0, dmem_req_o}, 32'd0);
        check32({"fwd_value ", name}, rd_value_mem_o, (wbsel == 2'b10) ? pc + 32'd4 : alu);
      end
      if (n == 1 && chk_bus) begin
        check32({"req ", name}, {31'd0, dmem_req_o}, 32'd1);
        check32({"we ", name}, {31'd0, dmem_we_o}, {31'd0, exp_we});
        check32({"addr ", name}, dmem_addr_o, exp_addr);
        check32({"be ", name}, {28'd0, dmem_be_o}, {28'd0, exp_be});
        if (exp_we) check32({"wdata ", name}, dmem_wdata_o, exp_wdata);
      end
      if (!stall_mem_o) break;
      if (n >= 30) begin
        checks++;
        failures++;
        $display("FAIL timeout %s: stall still %0d after %0d cycles, required 0", name, stall_mem_o, n);
        break;
      end
      n++;
      @(negedge clk_i);
    end
    check32({"stall_cycles ", name}, n, exp_stall);
    @(negedge clk_i);
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'd0;
  endtask

  task automatic nop(input string name);
    issue(0, 0, 0, 0, 0, 0, 5'd0, 2'b00, 0, 3'b000, 0, 0, mk(0, 1, 0, 0, 0, name),
          0, 0, 0, 0, 0, 0, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i        = 1'b1;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'd0;
    drive(0, 0, 0, 0, 0, 0, 5'd0, 2'b00, 0, 3'b000);
    repeat (3) @(negedge clk_i);
    check32("rst_req", {31'd0, dmem_req_o}, 32'd0);
    check32("rst_we", {31'd0, dmem_we_o}, 32'd0);
    check32("rst_addr", dmem_addr_o, 32'd0);
    check32("rst_wdata", dmem_wdata_o, 32'd0);
    check32("rst_be", {28'd0, dmem_be_o}, 32'd0);
    check32("rst_wb_value", rd_value_wb_o, 32'd0);
    check32("rst_wb_misc", {25'd0, reg_write_en_wb_o, rd_label_wb_o, misaligned_exc_o}, 32'd0);
    check32("rst_stall", {31'd0, stall_mem_o}, 32'd0);
    rst_i = 1'b0;

    issue(32'h10, 0, 0, 1, 0, 0, 5'd5, 2'b00, 32'h40, 3'b000, 0, 0,
          mk(32'h10, 1, 1, 5, 0, "add"), 0, 0, 0, 0, 0, 0, "add");
    issue(32'h999, 0, 0, 1, 0, 0, 5'd1, 2'b10, 32'h100, 3'b000, 0, 0,
          mk(32'h104, 1, 1, 1, 0, "jal"), 0, 0, 0, 0, 0, 0, "jal");
    issue(32'h1003, 0, 0, 1, 1, 0, 5'd7, 2'b01, 32'h44, 3'b000, 3, 32'h80FF_0000,
          mk(32'hFFFF_FF80, 1, 1, 7, 0, "lb"), 3, 1, 0, 32'h1000, 4'hF, 0, "lb");
    issue(32'h1003, 0, 0, 1, 1, 0, 5'd8, 2'b01, 32'h48, 3'b100, 3, 32'h80FF_0000,
          mk(32'h0000_0080, 1, 1, 8, 0, "lbu"), 3, 1, 0, 32'h1000, 4'hF, 0, "lbu");
    issue(32'h2002, 32'h1234_ABCD, 0, 0, 0, 1, 5'd0, 2'b00, 32'h4C, 3'b001, 1, 0,
          mk(32'h2002, 1, 0, 0, 0, "sh"), 1, 1, 1, 32'h2000, 4'b1100, 32'hABCD_ABCD, "sh");
    issue(32'h3001, 0, 0, 1, 1, 0, 5'd9, 2'b01, 32'h50, 3'b010, 0, 0,
          mk(0, 0, 0, 9, 1, "lw_mis"), 0, 0, 0, 0, 0, 0, "lw_mis");
    nop("nop_after_mis");
    dmem_ack_i = 1'b1;
    issue(32'h55, 0, 0, 1, 0, 0, 5'd2, 2'b00, 32'h54, 3'b000, 0, 0,
          mk(32'h55, 1, 1, 2, 0, "ack_idle"), 0, 0, 0, 0, 0, 0, "ack_idle");
    issue(32'h4002, 0, 0, 1, 1, 0, 5'd11, 2'b01, 32'h58, 3'b001, 2, 32'h8001_7FFF,
          mk(32'hFFFF_8001, 1, 1, 11, 0, "lh"), 2, 1, 0, 32'h4000, 4'hF, 0, "lh");
    issue(32'h4000, 0, 0, 1, 1, 0, 5'd12, 2'b01, 32'h5C, 3'b101, 1, 32'h8001_7FFF,
          mk(32'h0000_7FFF, 1, 1, 12, 0, "lhu"), 1, 1, 0, 32'h4000, 4'hF, 0, "lhu");
    issue(32'h5000, 0, 0, 1, 1, 0, 5'd10, 2'b01, 32'h60, 3'b010, 2, 32'hDEAD_BEEF,
          mk(32'hDEAD_BEEF, 1, 1, 10, 0, "lw"), 2, 1, 0, 32'h5000, 4'hF, 0, "lw");
    issue(32'h6000, 32'h1111_1111, 1, 0, 0, 1, 5'd0, 2'b00, 32'h64, 3'b010, 1, 0,
          mk(32'h6000, 1, 0, 0, 0, "sw_fwd"), 1, 1, 1, 32'h6000, 4'hF, 32'hDEAD_BEEF, "sw_fwd");
    issue(32'h7001, 32'h0000_00A5, 0, 0, 0, 1, 5'd0, 2'b00, 32'h68, 3'b000, 2, 0,
          mk(32'h7001, 1, 0, 0, 0, "sb"), 2, 1, 1, 32'h7000, 4'b0010, 32'hA5A5_A5A5, "sb");
    issue(32'h8000, 0, 0, 1, 1, 0, 5'd4, 2'b01, 32'h6C, 3'b011, 0, 0,
          mk(0, 0, 0, 4, 1, "f3_011"), 0, 0, 0, 0, 0, 0, "f3_011");
    issue(32'hABC, 0, 0, 1, 0, 0, 5'd13, 2'b00, 32'h70, 3'b000, 0, 0,
          mk(32'hABC, 1, 1, 13, 0, "add2"), 0, 0, 0, 0, 0, 0, "add2");

    // Reset arrives while an access is outstanding.
    drive(32'h9000, 0, 0, 1, 1, 0, 5'd3, 2'b01, 32'h74, 3'b010);
    #1;
    check32("rstacc_launch_stall", {31'd0, stall_mem_o}, 32'd1);
    @(negedge clk_i);
    check32("rstacc_req_before", {31'd0, dmem_req_o}, 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check32("rstacc_req", {31'd0, dmem_req_o}, 32'd0);
    check32("rstacc_stall", {31'd0, stall_mem_o}, 32'd0);
    check32("rstacc_wb_value", rd_value_wb_o, 32'd0);
    check32("rstacc_wb_misc", {25'd0, reg_write_en_wb_o, rd_label_wb_o, misaligned_exc_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    issue(32'h77, 0, 0, 1, 0, 0, 5'd6, 2'b00, 32'h78, 3'b000, 0, 0,
          mk(32'h77, 1, 1, 6, 0, "add_after_rst"), 0, 0, 0, 0, 0, 0, "add_after_rst");

    #2;
    check32("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
